alarm_set_controller: RTL and testbench
=======================================

ALARM_SET_CONTROLLER -- requirements
Module: alarm_set_controller

Interface
REQ-001 SHALL have parameter LOAD_CYCLES, default 12: cycles each load/stop strobe is held; legal range >= 1; default covers one alarm-clock 1 s tick (10 clocks).
REQ-002 SHALL have parameter SNOOZE_MIN, default 5: minutes added per snooze; legal range 1..59.
REQ-003 SHALL have port clock  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-low (0 = reset).
REQ-005 SHALL have ports btn_mode, btn_confirm, btn_inc  in  1 each  pre-debounced single-cycle button pulses.
REQ-006 SHALL have port alarm_active  in  1  alarm-clock Alarm output.
REQ-007 SHALL have ports hour_in1 out 2, hour_in0 out 4, minute_in1 out 4, minute_in0 out 4  BCD digits to the alarm clock.
REQ-008 SHALL have ports load_time, load_alarm, STOP_alarm, Alarm_ON  out  1 each  alarm-clock control.
REQ-009 SHALL have port mode_state  out  3  current FSM state encoding, for display blinking.

Function
REQ-010 SHALL implement states RUN, T_HOUR, T_MIN, A_HOUR, A_MIN, LOAD_T, LOAD_A, STOP.
REQ-011 SHALL hold two BCD edit registers, time_edit and alarm_edit (HH:MM).
REQ-012 SHALL apply button priority mode > confirm > inc per cycle; lower-priority simultaneous pulses are dropped.
REQ-013 SHALL advance on btn_mode: RUN->T_HOUR->T_MIN->A_HOUR->A_MIN->RUN; A_MIN->RUN issues no load.
REQ-014 SHALL, on btn_inc in T_HOUR/A_HOUR, increment the hour of the edited register 00..23, wrapping 23->00.
REQ-015 SHALL, on btn_inc in T_MIN/A_MIN, increment the minute 00..59, wrapping 59->00 without carry into the hour.
REQ-016 SHALL, on btn_confirm, go T_HOUR/T_MIN->LOAD_T and A_HOUR/A_MIN->LOAD_A.
REQ-017 SHALL assert load_time throughout LOAD_T and load_alarm throughout LOAD_A for exactly LOAD_CYCLES cycles, then return to RUN.
REQ-018 SHALL, in RUN with alarm_active=0, toggle Alarm_ON on btn_confirm.
REQ-019 SHALL, in RUN with alarm_active=1, treat btn_confirm or btn_inc as stop: enter STOP and assert STOP_alarm for LOAD_CYCLES cycles; Alarm_ON unchanged.
REQ-020 SHALL ignore all buttons in LOAD_T, LOAD_A and STOP.
REQ-021 SHALL drive the digit outputs from alarm_edit in A_HOUR, A_MIN, LOAD_A, and in STOP during a snooze; otherwise from time_edit.
REQ-022 SHALL register all outputs, with the state change taking effect one cycle after the button pulse.
REQ-023 SHALL keep edit registers valid BCD: hour_in1 <= 2, hour <= 23, minute_in1 <= 5.

Reset
REQ-024 SHALL, with reset=0 at a clock edge, enter RUN and set time_edit = alarm_edit = 00:00.
REQ-025 SHALL, under the same condition, set Alarm_ON, load_time, load_alarm and STOP_alarm to 0 and clear the hold counter.
REQ-026 SHALL abort any LOAD or STOP strobe on reset with no residual pulse.

Configuration
REQ-027 SHALL compile snooze in when macro ALARM_SNOOZE_EN is defined.
REQ-028 SHALL, with ALARM_SNOOZE_EN defined, make btn_inc in RUN with alarm_active=1 a snooze.
REQ-029 SHALL implement that snooze by adding SNOOZE_MIN to alarm_edit, carrying into the hour and wrapping 23:59->00:xx.
REQ-030 SHALL implement that snooze by entering STOP with STOP_alarm and load_alarm both asserted for LOAD_CYCLES cycles.
REQ-031 SHALL, without ALARM_SNOOZE_EN, treat that btn_inc as a plain stop per REQ-019.

Structure
REQ-032 SHALL place the state enum, BCD digit typedefs and the hour/minute limits 23/59 in shared package alarm_pkg.
REQ-033 SHALL use one sub-module, bcd_hhmm_inc: a combinational HH:MM BCD adder with mode inputs hour+1, minute+1 and minute+N with carry.

Verification
REQ-034 SHALL cover: reset, then btn_mode, btn_inc x3, btn_confirm -> load_time high 12 cycles with digits 03:00, then RUN.
REQ-035 SHALL cover: in A_MIN at minute 59, btn_inc -> minute 00, hour unchanged.
REQ-036 SHALL cover: btn_mode and btn_inc in the same cycle in RUN -> T_HOUR, time_edit unchanged.
REQ-037 SHALL cover: alarm_active=1, btn_confirm -> STOP_alarm high 12 cycles, Alarm_ON still 1.
REQ-038 SHALL cover: ALARM_SNOOZE_EN with alarm 23:58, btn_inc while active -> load_alarm and STOP_alarm high 12 cycles with digits 00:03.
REQ-039 SHALL cover: reset=0 during the 5th cycle of LOAD_T -> load_time low next cycle, state RUN, digits 00:00.

Source files
------------

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared states, BCD digit types, HH:MM limits and incrementer modes for the alarm setter
package alarm_pkg;

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_T_HOUR = 3'd1,
    S_T_MIN  = 3'd2,
    S_A_HOUR = 3'd3,
    S_A_MIN  = 3'd4,
    S_LOAD_T = 3'd5,
    S_LOAD_A = 3'd6,
    S_STOP   = 3'd7
  } state_e;

  typedef logic [1:0] bcd2_t;
  typedef logic [3:0] bcd4_t;

  typedef struct packed {
    bcd2_t h1;
    bcd4_t h0;
    bcd4_t m1;
    bcd4_t m0;
  } hhmm_t;

  typedef enum logic [1:0] {
    INC_HOUR  = 2'd0,
    INC_MIN   = 2'd1,
    INC_MIN_N = 2'd2
  } inc_mode_e;

  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;

endpackage

// File: rtl/bcd_hhmm_inc.sv
// rtl/bcd_hhmm_inc.sv - combinational HH:MM BCD incrementer: hour+1, minute+1 (no carry), minute+N (with carry)
module bcd_hhmm_inc
  import alarm_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  hhmm_t     val_i,
  input  inc_mode_e mode_i,
  output hhmm_t     val_o
);

  logic [4:0] hour_bin;
  logic [4:0] hour_wrap;
  logic [4:0] hour_nxt;
  logic [5:0] min_bin;
  logic [5:0] min_nxt;
  logic [6:0] min_sum;

  always_comb begin
    hour_bin  = 5'(val_i.h1) * 5'd10 + 5'(val_i.h0);
    min_bin   = 6'(val_i.m1) * 6'd10 + 6'(val_i.m0);
    hour_wrap = (hour_bin >= 5'(HOUR_MAX)) ? 5'd0 : hour_bin + 5'd1;
    min_sum   = 7'(min_bin) + 7'(N);
    hour_nxt  = hour_bin;
    min_nxt   = min_bin;
    unique case (mode_i)
      INC_HOUR: hour_nxt = hour_wrap;
      INC_MIN:  min_nxt  = (min_bin >= 6'(MIN_MAX)) ? 6'd0 : min_bin + 6'd1;
      INC_MIN_N: begin
        // Snooze may cross the hour (and midnight), unlike manual minute editing.
        if (min_sum > 7'(MIN_MAX)) begin
          min_nxt  = 6'(min_sum - 7'd60);
          hour_nxt = hour_wrap;
        end else begin
          min_nxt  = 6'(min_sum);
        end
      end
      default: ;
    endcase
    val_o.h1 = 2'(hour_nxt / 5'd10);
    val_o.h0 = 4'(hour_nxt % 5'd10);
    val_o.m1 = 4'(min_nxt / 6'd10);
    val_o.m0 = 4'(min_nxt % 6'd10);
  end

endmodule

// File: rtl/alarm_set_controller.sv
// rtl/alarm_set_controller.sv - button-driven time/alarm setter for an alarm clock; snooze built with ALARM_SNOOZE_EN
module alarm_set_controller
  import alarm_pkg::*;
#(
  parameter int unsigned LOAD_CYCLES = 12,
  parameter int unsigned SNOOZE_MIN  = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_confirm,
  input  logic       btn_inc,
  input  logic       alarm_active,
  output logic [1:0] hour_in1,
  output logic [3:0] hour_in0,
  output logic [3:0] minute_in1,
  output logic [3:0] minute_in0,
  output logic       load_time,
  output logic       load_alarm,
  output logic       STOP_alarm,
  output logic       Alarm_ON,
  output logic [2:0] mode_state
);

  localparam int unsigned CNT_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  state_e     state_q, state_d;
  hhmm_t      time_q, time_d;
  hhmm_t      alarm_q, alarm_d;
  hhmm_t      digits_q, digits_d;
  logic       alarm_on_q, alarm_on_d;
  logic       snooze_q, snooze_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       load_time_q, load_alarm_q, stop_q;
  logic [2:0] mode_state_q;

  logic       mode_p, conf_p, inc_p;
  hhmm_t      inc_src, inc_val;
  inc_mode_e  inc_mode;

  assign mode_p = btn_mode;
  assign conf_p = btn_confirm & ~btn_mode;
  assign inc_p  = btn_inc & ~btn_mode & ~btn_confirm;

  always_comb begin
    inc_src  = time_q;
    inc_mode = INC_MIN_N;
    unique case (state_q)
      S_T_HOUR: inc_mode = INC_HOUR;
      S_T_MIN:  inc_mode = INC_MIN;
      S_A_HOUR: begin inc_src = alarm_q; inc_mode = INC_HOUR; end
      S_A_MIN:  begin inc_src = alarm_q; inc_mode = INC_MIN;  end
      S_RUN:    inc_src = alarm_q;
      default: ;
    endcase
  end

  bcd_hhmm_inc #(.N(SNOOZE_MIN)) u_inc (
    .val_i  (inc_src),
    .mode_i (inc_mode),
    .val_o  (inc_val)
  );

  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    alarm_d    = alarm_q;
    alarm_on_d = alarm_on_q;
    snooze_d   = snooze_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (mode_p) begin
          state_d = S_T_HOUR;
        end else if (alarm_active && (conf_p || inc_p)) begin
          state_d  = S_STOP;
          cnt_d    = '0;
          snooze_d = 1'b0;
`ifdef ALARM_SNOOZE_EN
          if (inc_p) begin
            alarm_d  = inc_val;
            snooze_d = 1'b1;
          end
`endif
        end else if (conf_p) begin
          alarm_on_d = ~alarm_on_q;
        end
      end
      S_T_HOUR, S_T_MIN: begin
        if (mode_p) begin
          state_d = (state_q == S_T_HOUR) ? S_T_MIN : S_A_HOUR;
        end else if (conf_p) begin
          state_d = S_LOAD_T;
          cnt_d   = '0;
        end else if (inc_p) begin
          time_d = inc_val;
        end
      end
      S_A_HOUR, S_A_MIN: begin
        if (mode_p) begin
          state_d = (state_q == S_A_HOUR) ? S_A_MIN : S_RUN;
        end else if (conf_p) begin
          state_d = S_LOAD_A;
          cnt_d   = '0;
        end else if (inc_p) begin
          alarm_d = inc_val;
        end
      end
      default: begin
        // Strobe states ignore every button until the hold count expires.
        if (cnt_q == CNT_W'(LOAD_CYCLES - 1)) begin
          state_d  = S_RUN;
          snooze_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    digits_d = time_d;
    if (state_d == S_A_HOUR || state_d == S_A_MIN || state_d == S_LOAD_A ||
        (state_d == S_STOP && snooze_d)) begin
      digits_d = alarm_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_RUN;
      time_q       <= '0;
      alarm_q      <= '0;
      digits_q     <= '0;
      alarm_on_q   <= 1'b0;
      snooze_q     <= 1'b0;
      cnt_q        <= '0;
      load_time_q  <= 1'b0;
      load_alarm_q <= 1'b0;
      stop_q       <= 1'b0;
      mode_state_q <= S_RUN;
    end else begin
      state_q      <= state_d;
      time_q       <= time_d;
      alarm_q      <= alarm_d;
      digits_q     <= digits_d;
      alarm_on_q   <= alarm_on_d;
      snooze_q     <= snooze_d;
      cnt_q        <= cnt_d;
      load_time_q  <= (state_d == S_LOAD_T);
      load_alarm_q <= (state_d == S_LOAD_A) || (state_d == S_STOP && snooze_d);
      stop_q       <= (state_d == S_STOP);
      mode_state_q <= state_d;
    end
  end

  assign hour_in1   = digits_q.h1;
  assign hour_in0   = digits_q.h0;
  assign minute_in1 = digits_q.m1;
  assign minute_in0 = digits_q.m0;
  assign load_time  = load_time_q;
  assign load_alarm = load_alarm_q;
  assign STOP_alarm = stop_q;
  assign Alarm_ON   = alarm_on_q;
  assign mode_state = mode_state_q;

endmodule

// File: tb/tb_alarm_set_controller.sv
// tb/tb_alarm_set_controller.sv - directed self-checking bench for alarm_set_controller (snooze path under ALARM_SNOOZE_EN)
module tb_alarm_set_controller;

  logic       clock;
  logic       reset;
  logic       btn_mode, btn_confirm, btn_inc, alarm_active;
  logic [1:0] hour_in1;
  logic [3:0] hour_in0, minute_in1, minute_in0;
  logic       load_time, load_alarm, STOP_alarm, Alarm_ON;
  logic [2:0] mode_state;

  int errors = 0;
  int checks = 0;
  int n;

  alarm_set_controller dut (
    .clock        (clock),
    .reset        (reset),
    .btn_mode     (btn_mode),
    .btn_confirm  (btn_confirm),
    .btn_inc      (btn_inc),
    .alarm_active (alarm_active),
    .hour_in1     (hour_in1),
    .hour_in0     (hour_in0),
    .minute_in1   (minute_in1),
    .minute_in0   (minute_in0),
    .load_time    (load_time),
    .load_alarm   (load_alarm),
    .STOP_alarm   (STOP_alarm),
    .Alarm_ON     (Alarm_ON),
    .mode_state   (mode_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] digits();
    return {2'b00, hour_in1, hour_in0, minute_in1, minute_in0};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_mode();
    btn_mode = 1'b1; @(negedge clock); btn_mode = 1'b0;
  endtask
  task automatic pulse_conf();
    btn_confirm = 1'b1; @(negedge clock); btn_confirm = 1'b0;
  endtask
  task automatic pulse_inc(input int times);
    for (int i = 0; i < times; i++) begin
      btn_inc = 1'b1; @(negedge clock); btn_inc = 1'b0;
    end
  endtask

  // sel: 0 load_time, 1 load_alarm, 2 STOP_alarm, 3 load_alarm & STOP_alarm
  task automatic count_high(input int sel, output int cnt);
    logic v;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      case (sel)
        0: v = load_time;
        1: v = load_alarm;
        2: v = STOP_alarm;
        default: v = load_alarm & STOP_alarm;
      endcase
      if (v !== 1'b1) break;
      cnt++;
      @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b0; btn_mode = 1'b0; btn_confirm = 1'b0; btn_inc = 1'b0; alarm_active = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_state", 16'(mode_state), 16'd0);
    check("reset_digits", digits(), 16'h0000);
    check("reset_strobes", {13'd0, load_time, load_alarm, STOP_alarm}, 16'd0);
    check("reset_alarm_on", 16'(Alarm_ON), 16'd0);

    // Set time to 03:00 and load it
    pulse_mode();
    check("t_hour_state", 16'(mode_state), 16'd1);
    pulse_inc(3);
    check("t_hour_digits", digits(), 16'h0300);
    pulse_conf();
    check("load_t_state", 16'(mode_state), 16'd5);
    check("load_t_digits", digits(), 16'h0300);
    count_high(0, n);
    check("load_t_len", 16'(n), 16'd12);
    check("load_t_done_state", 16'(mode_state), 16'd0);

    // Simultaneous mode+inc: mode wins, inc dropped
    btn_mode = 1'b1; btn_inc = 1'b1;
    @(negedge clock);
    btn_mode = 1'b0; btn_inc = 1'b0;
    check("prio_state", 16'(mode_state), 16'd1);
    check("prio_digits", digits(), 16'h0300);
    pulse_mode();
    check("t_min_state", 16'(mode_state), 16'd2);
    pulse_inc(1);
    check("t_min_digits", digits(), 16'h0301);

    // Alarm hour wrap 23->00, then set 23
    pulse_mode();
    check("a_hour_state", 16'(mode_state), 16'd3);
    check("a_hour_digits", digits(), 16'h0000);
    pulse_inc(23);
    check("a_hour_23", digits(), 16'h2300);
    pulse_inc(1);
    check("a_hour_wrap", digits(), 16'h0000);
    pulse_inc(23);

    // Alarm minute 59->00 without hour carry, then set 58
    pulse_mode();
    check("a_min_state", 16'(mode_state), 16'd4);
    pulse_inc(59);
    check("a_min_59", digits(), 16'h2359);
    pulse_inc(1);
    check("a_min_wrap", digits(), 16'h2300);
    pulse_inc(58);
    check("a_min_58", digits(), 16'h2358);
    pulse_conf();
    check("load_a_state", 16'(mode_state), 16'd6);
    check("load_a_digits", digits(), 16'h2358);
    count_high(1, n);
    check("load_a_len", 16'(n), 16'd12);
    check("load_a_done_state", 16'(mode_state), 16'd0);
    check("run_digits_time", digits(), 16'h0301);

    // Alarm_ON toggle while alarm idle
    pulse_conf();
    check("alarm_on_toggle", 16'(Alarm_ON), 16'd1);

    // Stop via confirm while ringing
    alarm_active = 1'b1;
    pulse_conf();
    check("stop_state", 16'(mode_state), 16'd7);
    check("stop_no_load", 16'(load_alarm), 16'd0);
    count_high(2, n);
    check("stop_len", 16'(n), 16'd12);
    check("stop_alarm_on", 16'(Alarm_ON), 16'd1);
    check("stop_done_state", 16'(mode_state), 16'd0);

    // btn_inc while ringing: snooze or plain stop
    pulse_inc(1);
    check("inc_stop_state", 16'(mode_state), 16'd7);
`ifdef ALARM_SNOOZE_EN
    check("snooze_digits", digits(), 16'h0003);
    count_high(3, n);
    check("snooze_len", 16'(n), 16'd12);
`else
    check("plain_stop_load", 16'(load_alarm), 16'd0);
    check("plain_stop_digits", digits(), 16'h0301);
    count_high(2, n);
    check("plain_stop_len", 16'(n), 16'd12);
`endif
    check("inc_stop_done", 16'(mode_state), 16'd0);
    check("inc_stop_alarm_on", 16'(Alarm_ON), 16'd1);

    // Buttons ignored in LOAD_T, then reset in its 5th cycle
    alarm_active = 1'b0;
    pulse_mode();
    pulse_conf();
    pulse_mode();
    check("load_ignore_mode", 16'(mode_state), 16'd5);
    pulse_inc(1);
    check("load_ignore_inc", digits(), 16'h0301);
    @(negedge clock);
    @(negedge clock);
    check("load_t_cycle5", 16'(load_time), 16'd1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("abort_load_time", 16'(load_time), 16'd0);
    check("abort_state", 16'(mode_state), 16'd0);
    check("abort_digits", digits(), 16'h0000);
    check("abort_alarm_on", 16'(Alarm_ON), 16'd0);
    @(negedge clock);
    check("abort_no_residual", {13'd0, load_time, load_alarm, STOP_alarm}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
